// File: rtl/arb_wrr_sched.sv
// Weighted round-robin scheduler sharing output port D between passes A/B/C.
// Grants one pass per burst of up to weight beats, honours backpressure, no bubble on handoff.
module arb_wrr_sched #(
    parameter int unsigned NREQ           = 3,
    parameter int unsigned WW             = 4,
    parameter int unsigned DEFAULT_WEIGHT = 4
) (
    input  logic            CLK,
    input  logic            ASynReset_N,
    input  logic [NREQ-1:0] i_Req,
    input  logic            i_DstReady,
    input  logic            i_CfgWe,
    input  logic [1:0]      i_CfgSel,
    input  logic [WW-1:0]   i_CfgWeight,
    output logic [NREQ-1:0] o_Grant,
    output logic [1:0]      o_Owner,
    output logic [WW-1:0]   o_BeatCnt
);

    localparam logic [1:0] OwnerNone = 2'd3;

    typedef enum logic {StIdle, StBurst} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [WW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   limit_q, limit_d;
    logic [WW-1:0]   weight_q [NREQ];
    logic [WW-1:0]   weight_d [NREQ];

    logic [NREQ-1:0] elig;
    logic            found;
    logic [1:0]      winner;
    logic [1:0]      cand;
    logic            owner_req;
    logic            beat;
    logic            burst_end;
    logic            load;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = i_Req[i] && (weight_q[i] != '0);
        end
    end

    // Search starts just after the last-served index; the last owner is checked last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = 2'((32'(ptr_q) + k) % NREQ);
            if (!found && elig[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        owner_req = (state_q == StBurst) && i_Req[owner_q];
        beat      = owner_req && i_DstReady;
        burst_end = (state_q == StBurst) &&
                    (!owner_req || (beat && ((cnt_q + 1'b1) == limit_q)));
        load      = found && ((state_q == StIdle) || burst_end);
    end

    // State register
    always_ff @(posedge CLK or negedge ASynReset_N) begin
        if (!ASynReset_N) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= OwnerNone;
            ptr_q   <= 2'(NREQ - 1);
            cnt_q   <= '0;
            limit_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                weight_q[i] <= WW'(DEFAULT_WEIGHT);
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            limit_q  <= limit_d;
            weight_q <= weight_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (found) state_d = StBurst;
            StBurst: if (burst_end && !found) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Registered-output and datapath next values
    always_comb begin
        grant_d  = grant_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        limit_d  = limit_q;
        weight_d = weight_q;

        if (load) begin
            grant_d = {{(NREQ-1){1'b0}}, 1'b1} << winner;
            owner_d = winner;
            ptr_d   = winner;
            cnt_d   = '0;
            limit_d = weight_q[winner];
        end else if (burst_end) begin
            grant_d = '0;
            owner_d = OwnerNone;
            cnt_d   = '0;
        end else if (beat) begin
            cnt_d = cnt_q + 1'b1;
        end

        // The running burst keeps its latched limit; a new weight applies from the next burst.
        if (i_CfgWe && (32'(i_CfgSel) < NREQ)) begin
            weight_d[i_CfgSel] = i_CfgWeight;
        end
    end

    assign o_Grant   = grant_q;
    assign o_Owner   = owner_q;
    assign o_BeatCnt = cnt_q;

endmodule
